lux_filter: RTL and testbench
=============================

LUX_FILTER -- requirements
Module: lux_filter

Interface
REQ-001 Parameter TH_HIGH, default 16'd500, threshold-set level in lux applied to avg_lux.
REQ-002 Parameter TH_LOW, default 16'd400, threshold-clear level in lux; TH_LOW SHALL be <= TH_HIGH.
REQ-003 clk  input  1  system clock, 12 MHz; all state SHALL be updated on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 data_valid  input  1  one-cycle pulse from the I2C controller when a sensor read completes.
REQ-006 sensor_data  input  16  raw BH1750 count, {high byte, low byte}; sampled only when data_valid=1.
REQ-007 clear  input  1  synchronous flush of the filter.
REQ-008 lux  output  16  latest converted sample, in lux.
REQ-009 lux_valid  output  1  one-cycle pulse when lux updates.
REQ-010 avg_lux  output  16  4-sample moving average of lux.
REQ-011 avg_valid  output  1  one-cycle pulse when avg_lux updates.
REQ-012 avg_full  output  1  high once 4 samples have entered the window since reset or clear.
REQ-013 above_thresh  output  1  hysteresis comparator output on avg_lux.

Function
REQ-014 The pipeline SHALL have stage 0 (capture), stage 1 (convert) and stage 2 (average and threshold), accepting one sample per cycle with no stall and no backpressure.
REQ-015 Stage 0: on data_valid=1, the block SHALL register sensor_data and set an internal valid flag for one cycle.
REQ-016 Stage 1: lux SHALL equal (raw*16'd54613 + 32'd32768) >> 16 using a 32-bit unsigned product, truncated to 16 bits (round-to-nearest raw/1.2).
REQ-017 Stage 1 timing: lux and lux_valid SHALL update 2 cycles after the data_valid edge. lux SHALL hold its value between updates.
REQ-018 Window: a 4-entry ring buffer of 16-bit lux values, a 2-bit write pointer wrapping 3->0, and an 18-bit running sum.
REQ-019 Sum update: on each new lux value, sum_next = sum - buf[ptr] + lux, buf[ptr] = lux, ptr = ptr+1; the sum SHALL never overflow or saturate.
REQ-020 Average: avg_lux = sum_next >> 2, registered together with avg_valid 3 cycles after the data_valid edge.
REQ-021 Empty slots: empty buffer slots SHALL hold 0, so before the window fills avg_lux is the partial sum divided by 4.
REQ-022 avg_full: a 3-bit sample counter SHALL saturate at 4; avg_full = (count == 4).
REQ-023 Threshold set/clear: above_thresh SHALL update in the same cycle as avg_lux. It sets when new avg_lux >= TH_HIGH, clears when new avg_lux < TH_LOW, and otherwise holds.
REQ-024 Threshold hold: above_thresh SHALL change only on cycles where avg_valid=1.
REQ-025 Back-to-back: data_valid on consecutive cycles SHALL produce lux_valid and avg_valid on consecutive cycles, with every sample processed in order.
REQ-026 clear: clear=1 SHALL zero the buffer, sum, pointer, count, avg_lux and above_thresh on the next edge, and SHALL flush both pipeline valid flags so no lux_valid or avg_valid pulse results from samples in flight.
REQ-027 clear priority: clear SHALL win over a simultaneous data_valid, and that sample SHALL be discarded.
REQ-028 lux on clear: lux SHALL retain its last value on clear.

Reset
REQ-029 While reset=0, the following SHALL be 0 immediately, independent of clk: lux, lux_valid, avg_lux, avg_valid, avg_full, above_thresh, the buffer, sum, pointer, count and all pipeline flags.
REQ-030 Reset asserted mid-pipeline SHALL discard all in-flight samples; after release, the first data_valid behaves as the first sample after power-up.
REQ-031 Reset release SHALL take effect at the first rising clk edge after reset returns to 1.

Verification
REQ-032 Conversion: single data_valid with sensor_data=16'hDEAD -> lux=16'hB990 with lux_valid 2 cycles later; avg_lux=16'h2E64 with avg_valid 3 cycles later; avg_full=0.
REQ-033 Rounding and saturation: raw 600 -> lux 500; raw 599 -> 499; raw 480 -> 400; raw 479 -> 399; raw 16'hFFFF -> 54612; raw 0 -> 0.
REQ-034 Window fill and hysteresis up: four samples of raw 1200 -> avg_lux 250, 500, 750, 1000; above_thresh rises on the 2nd sample; avg_full rises on the 4th.
REQ-035 Wrap and hysteresis down: following REQ-034, four samples of raw 0 -> avg_lux 750, 500, 250, 0; above_thresh stays 1 through 500 and clears at 250; pointer wraps without a glitch.
REQ-036 Back-to-back and clear: four data_valid pulses on consecutive cycles (raw 1200) -> four consecutive avg_valid pulses ending at 1000. Then clear coincident with a data_valid -> all window outputs 0, no valid pulse, next raw 1200 -> avg_lux 250.
REQ-037 Async reset: assert reset=0 one cycle after data_valid -> all outputs 0 at once, no later lux_valid or avg_valid; release, then raw 600 -> lux 500, avg_lux 125.

Source files
------------

// File: rtl/lux_filter.sv
// rtl/lux_filter.sv - three-stage BH1750 lux conversion, 4-sample moving average and hysteresis comparator
//
// Ports:
//   clk          in   rising-edge system clock
//   reset        in   asynchronous active-low reset
//   data_valid   in   one-cycle pulse, sensor_data holds a completed read
//   sensor_data  in   16-bit raw BH1750 count {high byte, low byte}
//   clear        in   synchronous flush of window, comparator and in-flight samples
//   lux          out  latest converted sample in lux (holds between updates)
//   lux_valid    out  one-cycle pulse when lux updates
//   avg_lux      out  4-sample moving average of lux
//   avg_valid    out  one-cycle pulse when avg_lux updates
//   avg_full     out  high once 4 samples have entered the window
//   above_thresh out  hysteresis comparator on avg_lux (set >= TH_HIGH, clear < TH_LOW)

module lux_filter #(
   parameter logic [15:0] TH_HIGH = 16'd500,
   parameter logic [15:0] TH_LOW  = 16'd400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_valid,
   input  logic [15:0] sensor_data,
   input  logic        clear,
   output logic [15:0] lux,
   output logic        lux_valid,
   output logic [15:0] avg_lux,
   output logic        avg_valid,
   output logic        avg_full,
   output logic        above_thresh
);

   // Stage 0: capture
   logic [15:0] raw_q;
   logic        s0_valid;

   // Stage 2: averaging window
   logic [15:0] win_buf [4];
   logic [1:0]  ptr;
   logic [17:0] sum;
   logic [2:0]  count;

   // Combinational helpers
   logic [15:0] lux_conv;
   logic [17:0] sum_next;
   logic [15:0] avg_next;
   logic        above_next;

   // raw/1.2 rounded to nearest: 54613/65536 ~= 1/1.2, +32768 rounds the
   // 16-bit right shift. The 32-bit product cannot overflow for any raw.
   always_comb begin
      lux_conv = 16'(((32'(raw_q) * 32'd54613) + 32'd32768) >> 16);
   end

   // The oldest slot leaves the window as the new sample enters. Empty slots
   // are zero, so the same update works while the window is still filling.
   always_comb begin
      sum_next = sum - {2'b00, win_buf[ptr]} + {2'b00, lux};
      avg_next = 16'(sum_next >> 2);
      above_next = above_thresh;
      if (avg_next >= TH_HIGH) begin
         above_next = 1'b1;
      end else if (avg_next < TH_LOW) begin
         above_next = 1'b0;
      end
   end

   // Stage 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         raw_q    <= 16'd0;
         s0_valid <= 1'b0;
      end else if (clear) begin
         // A sample arriving with clear is discarded.
         s0_valid <= 1'b0;
      end else begin
         s0_valid <= data_valid;
         if (data_valid) begin
            raw_q <= sensor_data;
         end
      end
   end

   // Stage 1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lux       <= 16'd0;
         lux_valid <= 1'b0;
      end else if (clear) begin
         // lux keeps its last value; only the in-flight flag is flushed.
         lux_valid <= 1'b0;
      end else begin
         lux_valid <= s0_valid;
         if (s0_valid) begin
            lux <= lux_conv;
         end
      end
   end

   // Stage 2
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            win_buf[i] <= 16'd0;
         end
         ptr          <= 2'd0;
         sum          <= 18'd0;
         count        <= 3'd0;
         avg_lux      <= 16'd0;
         avg_valid    <= 1'b0;
         above_thresh <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < 4; i++) begin
            win_buf[i] <= 16'd0;
         end
         ptr          <= 2'd0;
         sum          <= 18'd0;
         count        <= 3'd0;
         avg_lux      <= 16'd0;
         avg_valid    <= 1'b0;
         above_thresh <= 1'b0;
      end else begin
         avg_valid <= lux_valid;
         if (lux_valid) begin
            win_buf[ptr] <= lux;
            ptr          <= ptr + 2'd1;
            sum          <= sum_next;
            avg_lux      <= avg_next;
            above_thresh <= above_next;
            if (count != 3'd4) begin
               count <= count + 3'd1;
            end
         end
      end
   end

   assign avg_full = (count == 3'd4);

endmodule

// File: tb/tb_lux_filter.sv
// tb/tb_lux_filter.sv - scoreboard bench for lux_filter with directed vectors

module tb_lux_filter;

   logic        clk;
   logic        reset;
   logic        data_valid;
   logic [15:0] sensor_data;
   logic        clear;
   logic [15:0] lux;
   logic        lux_valid;
   logic [15:0] avg_lux;
   logic        avg_valid;
   logic        avg_full;
   logic        above_thresh;

   lux_filter dut (
      .clk          (clk),
      .reset        (reset),
      .data_valid   (data_valid),
      .sensor_data  (sensor_data),
      .clear        (clear),
      .lux          (lux),
      .lux_valid    (lux_valid),
      .avg_lux      (avg_lux),
      .avg_valid    (avg_valid),
      .avg_full     (avg_full),
      .above_thresh (above_thresh)
   );

   typedef struct packed {
      logic [31:0] cyc;
      logic [15:0] val;
   } lux_exp_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic [15:0] avg;
      logic        full;
      logic        above;
   } avg_exp_t;

   lux_exp_t    lux_q[$];
   avg_exp_t    avg_q[$];
   logic [15:0] last_lux;
   logic [31:0] cyc;
   int          total;
   int          bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 32'd0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops and compares whenever the DUT presents a valid output.
   always @(negedge clk) begin
      lux_exp_t le;
      avg_exp_t ae;
      if (lux_valid) begin
         if (lux_q.size() == 0) begin
            check("lux_unexpected", 32'd1, 32'd0);
         end else begin
            le = lux_q.pop_front();
            check("lux_cycle", cyc, le.cyc);
            check("lux_value", 32'(lux), 32'(le.val));
            last_lux = le.val;
         end
      end else if (reset) begin
         check("lux_hold", 32'(lux), 32'(last_lux));
      end
      if (avg_valid) begin
         if (avg_q.size() == 0) begin
            check("avg_unexpected", 32'd1, 32'd0);
         end else begin
            ae = avg_q.pop_front();
            check("avg_cycle", cyc, ae.cyc);
            check("avg_value", 32'(avg_lux), 32'(ae.avg));
            check("avg_full", 32'(avg_full), 32'(ae.full));
            check("above_thresh", 32'(above_thresh), 32'(ae.above));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called 1 time unit after a rising edge; the sample is taken on the next edge.
   task automatic send(input logic [15:0] raw, input logic [15:0] e_lux,
                       input logic [15:0] e_avg, input logic e_full, input logic e_above);
      lux_exp_t le;
      avg_exp_t ae;
      le.cyc = cyc + 32'd2;
      le.val = e_lux;
      ae.cyc = cyc + 32'd3;
      ae.avg = e_avg;
      ae.full = e_full;
      ae.above = e_above;
      lux_q.push_back(le);
      avg_q.push_back(ae);
      data_valid  = 1'b1;
      sensor_data = raw;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clr_avg_lux", 32'(avg_lux), 32'd0);
      check("clr_avg_full", 32'(avg_full), 32'd0);
      check("clr_above", 32'(above_thresh), 32'd0);
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      last_lux    = 16'd0;
      reset       = 1'b0;
      data_valid  = 1'b0;
      clear       = 1'b0;
      sensor_data = 16'd0;

      #2;
      check("rst_lux", 32'(lux), 32'd0);
      check("rst_lux_valid", 32'(lux_valid), 32'd0);
      check("rst_avg_lux", 32'(avg_lux), 32'd0);
      check("rst_avg_valid", 32'(avg_valid), 32'd0);
      check("rst_avg_full", 32'(avg_full), 32'd0);
      check("rst_above", 32'(above_thresh), 32'd0);
      #20;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single conversion
      send(16'hDEAD, 16'hB990, 16'h2E64, 1'b0, 1'b1);
      idle(4);
      do_clear();

      // Rounding, saturation, partial-window averages
      send(16'd600,   16'd500,   16'd125,   1'b0, 1'b0); idle(1);
      send(16'd599,   16'd499,   16'd249,   1'b0, 1'b0); idle(1);
      send(16'd480,   16'd400,   16'd349,   1'b0, 1'b0); idle(1);
      send(16'd479,   16'd399,   16'd449,   1'b1, 1'b0); idle(1);
      send(16'hFFFF,  16'd54612, 16'd13977, 1'b1, 1'b1); idle(1);
      send(16'd0,     16'd0,     16'd13852, 1'b1, 1'b1);
      idle(4);
      do_clear();

      // Window fill and hysteresis up
      send(16'd1200, 16'd1000, 16'd250,  1'b0, 1'b0); idle(2);
      send(16'd1200, 16'd1000, 16'd500,  1'b0, 1'b1); idle(2);
      send(16'd1200, 16'd1000, 16'd750,  1'b0, 1'b1); idle(2);
      send(16'd1200, 16'd1000, 16'd1000, 1'b1, 1'b1); idle(2);
      // Wrap and hysteresis down
      send(16'd0, 16'd0, 16'd750, 1'b1, 1'b1); idle(2);
      send(16'd0, 16'd0, 16'd500, 1'b1, 1'b1); idle(2);
      send(16'd0, 16'd0, 16'd250, 1'b1, 1'b0); idle(2);
      send(16'd0, 16'd0, 16'd0,   1'b1, 1'b0);
      idle(4);
      do_clear();

      // Back-to-back
      send(16'd1200, 16'd1000, 16'd250,  1'b0, 1'b0);
      send(16'd1200, 16'd1000, 16'd500,  1'b0, 1'b1);
      send(16'd1200, 16'd1000, 16'd750,  1'b0, 1'b1);
      send(16'd1200, 16'd1000, 16'd1000, 1'b1, 1'b1);
      idle(4);

      // Clear coincident with a sample: sample discarded, lux retained
      data_valid  = 1'b1;
      sensor_data = 16'd1200;
      do_clear();
      data_valid = 1'b0;
      check("clr_lux_retained", 32'(lux), 32'd1000);
      idle(4);
      send(16'd1200, 16'd1000, 16'd250, 1'b0, 1'b0);
      idle(4);

      // Asynchronous reset one cycle after a sample
      data_valid  = 1'b1;
      sensor_data = 16'd600;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      reset      = 1'b0;
      last_lux   = 16'd0;
      #1;
      check("arst_lux", 32'(lux), 32'd0);
      check("arst_lux_valid", 32'(lux_valid), 32'd0);
      check("arst_avg_lux", 32'(avg_lux), 32'd0);
      check("arst_avg_valid", 32'(avg_valid), 32'd0);
      check("arst_avg_full", 32'(avg_full), 32'd0);
      check("arst_above", 32'(above_thresh), 32'd0);
      idle(3);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      send(16'd600, 16'd500, 16'd125, 1'b0, 1'b0);
      idle(5);

      check("lux_q_drained", lux_q.size(), 32'd0);
      check("avg_q_drained", avg_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
